ssp_rx_path: RTL
================

# ssp_rx_path

Receive half of the SSP: deserializes TI-style synchronous-serial frames from SSPRXD/SSPCLKIN/SSPFSSIN into 8-bit words and buffers them in a small FIFO read over the PSEL/PWRITE/PRDATA bus. It sits directly downstream of the serial pins, which are looped back from SSPTXD/SSPCLKOUT/SSPFSSOUT. It feeds the host read path and raises SSPRXINTR when the buffer is full. Everything runs in the PCLK domain; SSPCLKIN is edge-detected, never used as a clock.

## Interface
- WIDTH, 8, serial word width in bits (MSB first)
- DEPTH, 4, FIFO entries; power of two, at least 2

- PCLK  in  1  system clock; all state updates on rising edge
- CLEAR_B  in  1  asynchronous active-low reset
- PSEL  in  1  bus select
- PWRITE  in  1  bus direction; a read is PSEL=1 and PWRITE=0
- PRDATA  out  WIDTH  FIFO head word; 0 when the FIFO is empty
- SSPCLKIN  in  1  serial clock, at most PCLK/2 rate
- SSPFSSIN  in  1  frame sync, high for one serial clock period before the MSB
- SSPRXD  in  1  serial data
- SSPRXINTR  out  1  high while the FIFO holds DEPTH words

## Operation
- Edge detect: register sclk_q <= SSPCLKIN on every PCLK edge (reset value 0).
  - A falling edge ("fe") is sclk_q=1 and SSPCLKIN=0 at a PCLK edge.
  - SSPRXD and SSPFSSIN are sampled only at fe edges.
- FSM states: IDLE, SHIFT; bit counter 0..WIDTH-1; shift register WIDTH bits.
  - IDLE: at fe with SSPFSSIN=1, go to SHIFT with bit=0. Otherwise stay.
  - SHIFT: at fe, shift SSPRXD into the LSB of the shift register and increment the counter.
  - SHIFT, last bit (bit=WIDTH-1) at fe:
    - Push the word {shift[WIDTH-2:0], SSPRXD}.
    - If SSPFSSIN=1 at that same fe (back-to-back frame), stay in SHIFT with bit=0.
    - Otherwise go to IDLE.
  - SHIFT, bit 0..WIDTH-2 with SSPFSSIN=1 at fe: the partial word is discarded and the frame restarts (bit=0). The current bit is not stored.
- FIFO: circular, with rd_ptr, wr_ptr and count (0..DEPTH).
  - PRDATA = mem[rd_ptr] when count>0, else 0.
  - Pop at a PCLK edge when PSEL=1, PWRITE=0 and count>0. A read of an empty FIFO has no effect.
  - Push when the FSM completes a word.
  - Push and pop on the same edge: both occur and count is unchanged. This applies when full too; no overflow results.
  - Push into a full FIFO with no pop: see Configuration.
  - Pointers wrap modulo DEPTH.
- SSPRXINTR = (count==DEPTH), decoded from registered count.

## Timing
- Reset (async, CLEAR_B=0): PRDATA=0, SSPRXINTR=0, FSM=IDLE, counters, pointers and shift register cleared, sclk_q=0.
- Reset mid-frame discards the partial word and all FIFO contents.
- Latency: the word is written on the PCLK edge that detects the WIDTH-th data fe. PRDATA and SSPRXINTR reflect it immediately after that edge.
- Pop: PRDATA advances to the next entry, or 0, immediately after the read edge. One word per PCLK cycle while the read is held.
- Minimum frame spacing: none. Back-to-back frames with FSS overlapping the LSB cycle are received without gaps.

## Configuration
- SSP_RX_OVERWRITE_EN defined: a push into a full FIFO without a pop overwrites the oldest entry.
  - Both pointers advance, count stays DEPTH, SSPRXINTR stays 1.
- Not defined (default): a push into a full FIFO without a pop is discarded. FIFO state is unchanged.

## Test plan
- Reset: CLEAR_B=0 with SSPCLKIN toggling and SSPRXD=1 -> PRDATA=0x00 and SSPRXINTR=0 throughout; release -> no spurious word.
- Single frame 0x35 (FSS pulse, then 8 bits MSB first):
  - PRDATA=0x35 on the edge after the 8th fe; SSPRXINTR=0.
  - One-cycle read -> PRDATA=0x00.
- Back-to-back frames 0x94, 0x0F, 0x51, 0x24 with FSS during each LSB -> SSPRXINTR=1 after the 4th; four reads return them in that order, then PRDATA=0x00 and SSPRXINTR=0.
- Fifth frame 0x67 while full:
  - Without the macro: reads return 0x94, 0x0F, 0x51, 0x24.
  - With SSP_RX_OVERWRITE_EN: reads return 0x0F, 0x51, 0x24, 0x67.
- Full FIFO; read held so that the pop coincides with the completion of frame 0xF3 -> SSPRXINTR stays 1; order is 0x0F, 0x51, 0x24, 0xF3 (default build, starting from 0x94..0x24).
- Resync and reset:
  - FSS re-asserted after 3 bits of a frame, then 0xAE sent -> only 0xAE received.
  - CLEAR_B pulsed after 5 bits of a frame, then 0xB6 sent -> only 0xB6 received.

Source files
------------

// File: rtl/ssp_rx_path_if.sv
// rtl/ssp_rx_path_if.sv - host read bus, serial receive pins and interrupt for ssp_rx_path
interface ssp_rx_path_if #(
  parameter int WIDTH = 8
);
  logic             PSEL;
  logic             PWRITE;
  logic [WIDTH-1:0] PRDATA;
  logic             SSPCLKIN;
  logic             SSPFSSIN;
  logic             SSPRXD;
  logic             SSPRXINTR;

  modport master (
    output PSEL, PWRITE, SSPCLKIN, SSPFSSIN, SSPRXD,
    input  PRDATA, SSPRXINTR
  );

  modport slave (
    input  PSEL, PWRITE, SSPCLKIN, SSPFSSIN, SSPRXD,
    output PRDATA, SSPRXINTR
  );
endinterface

// File: rtl/ssp_rx_path.sv
// rtl/ssp_rx_path.sv - SSP receive deserializer and read FIFO
// SSP_RX_OVERWRITE_EN: a push into a full FIFO replaces the oldest word instead of being dropped.
module ssp_rx_path #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         PCLK,
  input  logic         CLEAR_B,
  ssp_rx_path_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shift;
  logic             r_sclk_q;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_fe;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  // SSPCLKIN is only sampled; its falling edge is a PCLK-domain strobe.
  assign w_fe   = r_sclk_q & ~bus.SSPCLKIN;
  assign w_last = (r_bit == BW'(WIDTH - 1));
  assign w_push = w_fe && (r_state == SHIFT) && w_last;
  assign w_word = {r_shift[WIDTH-2:0], bus.SSPRXD};

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_state  <= IDLE;
      r_bit    <= '0;
      r_shift  <= '0;
      r_sclk_q <= 1'b0;
    end else begin
      r_sclk_q <= bus.SSPCLKIN;
      if (w_fe) begin
        case (r_state)
          IDLE: begin
            if (bus.SSPFSSIN) begin
              r_state <= SHIFT;
              r_bit   <= '0;
            end
          end
          SHIFT: begin
            if (w_last) begin
              r_shift <= w_word;
              r_bit   <= '0;
              r_state <= bus.SSPFSSIN ? SHIFT : IDLE;
            end else if (bus.SSPFSSIN) begin
              r_bit <= '0;
            end else begin
              r_shift <= w_word;
              r_bit   <= r_bit + BW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = bus.PSEL && !bus.PWRITE && (r_count != '0);

`ifdef SSP_RX_OVERWRITE_EN
  assign w_wr   = w_push;
  assign w_drop = w_push && w_full && !w_pop;
`else
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // A dropped oldest entry advances the read pointer exactly like a pop.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop || w_drop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr && !w_pop && !w_drop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign bus.PRDATA    = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.SSPRXINTR = w_full;
endmodule
